// File: rtl/pit_programmer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pit_programmer_if
//  Brief    : Timer-block bus between the PIT programmer and the 8254 core.
//  Revision : 1.0
// ============================================================================
interface pit_programmer_if;
    logic        cs;
    logic [1:1]  data_m_addr;
    logic [15:0] data_m_data_out;
    logic [1:0]  data_m_bytesel;
    logic        data_m_wr_en;
    logic        data_m_access;
    logic [15:0] data_m_data_in;
    logic        data_m_ack;

    modport master (
        output cs, data_m_addr, data_m_data_out, data_m_bytesel,
        output data_m_wr_en, data_m_access,
        input  data_m_data_in, data_m_ack
    );

    modport slave (
        input  cs, data_m_addr, data_m_data_out, data_m_bytesel,
        input  data_m_wr_en, data_m_access,
        output data_m_data_in, data_m_ack
    );
endinterface
`default_nettype wire

// File: rtl/pit_programmer.sv
`default_nettype none
// ============================================================================
//  Module   : pit_programmer
//  Brief    : Sequences control word, reload bytes and optional latched
//             read-back of one PIT channel over the timer-block bus.
//  Revision : 1.0
// ============================================================================
module pit_programmer #(
    parameter int ACK_TIMEOUT = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic        chan_sel,
    input  wire logic [1:0]  mode,
    input  wire logic [15:0] reload,
    input  wire logic        readback_en,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      count,
    output logic             count_valid,
    pit_programmer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, CTRL, LOAD_LO, LOAD_HI, LATCH, READ_LO, READ_HI, FINISH
    } state_t;

    typedef enum logic {
        PH_STROBE = 1'b0,
        PH_WAIT   = 1'b1
    } phase_t;

    localparam logic [7:0] c_tmo_last = 8'(ACK_TIMEOUT - 1);

    state_t      r_state, w_state_nxt, w_after;
    phase_t      r_phase, w_phase_nxt;
    logic [7:0]  r_tmo;
    logic        r_chan, r_rb, r_error, r_count_valid;
    logic [1:0]  r_mode;
    logic [15:0] r_reload, r_count;

    logic        w_access, w_addr, w_wr, w_ack_take, w_timeout, w_accept, w_waiting;
    logic [1:0]  w_bytesel, w_ch;
    logic [15:0] w_data;
    wire  logic  w_unused = &{1'b0, bus.data_m_data_in[15:8]};

    assign w_ch      = r_chan ? 2'b10 : 2'b00;
    assign w_accept  = (r_state == IDLE) && start;
    assign w_waiting = (r_state != IDLE) && (r_state != FINISH) && (r_phase == PH_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_phase <= PH_STROBE;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_after     = FINISH;
        w_access    = 1'b0;
        w_addr      = 1'b0;
        w_bytesel   = 2'b00;
        w_wr        = 1'b0;
        w_data      = 16'h0000;
        w_ack_take  = 1'b0;
        w_timeout   = 1'b0;

        // Per-state bus fields; only reach the pins during STROBE.
        case (r_state)
            CTRL: begin
                w_addr = 1'b1; w_bytesel = 2'b10; w_wr = 1'b1;
                w_data = {w_ch, 2'b11, 1'b0, r_mode, 1'b0, 8'h00};
                w_after = LOAD_LO;
            end
            LOAD_LO: begin
                w_addr = r_chan; w_bytesel = 2'b01; w_wr = 1'b1;
                w_data = {8'h00, r_reload[7:0]};
                w_after = LOAD_HI;
            end
            LOAD_HI: begin
                w_addr = r_chan; w_bytesel = 2'b01; w_wr = 1'b1;
                w_data = {8'h00, r_reload[15:8]};
                w_after = r_rb ? LATCH : FINISH;
            end
            LATCH: begin
                w_addr = 1'b1; w_bytesel = 2'b10; w_wr = 1'b1;
                w_data = {w_ch, 6'b000000, 8'h00};
                w_after = READ_LO;
            end
            READ_LO: begin
                w_addr = r_chan; w_bytesel = 2'b01;
                w_after = READ_HI;
            end
            READ_HI: begin
                w_addr = r_chan; w_bytesel = 2'b01;
                w_after = FINISH;
            end
            default: ;
        endcase

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = CTRL;
                    w_phase_nxt = PH_STROBE;
                end
            end
            FINISH: w_state_nxt = IDLE;
            default: begin
                if (r_phase == PH_STROBE) begin
                    w_access    = 1'b1;
                    w_phase_nxt = PH_WAIT;
                end else if (bus.data_m_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = w_after;
                    w_phase_nxt = PH_STROBE;
                end else if (r_tmo == c_tmo_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = FINISH;
                    w_phase_nxt = PH_STROBE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo         <= 8'h00;
            r_chan        <= 1'b0;
            r_mode        <= 2'b00;
            r_reload      <= 16'h0000;
            r_rb          <= 1'b0;
            r_error       <= 1'b0;
            r_count       <= 16'h0000;
            r_count_valid <= 1'b0;
        end else begin
            r_tmo <= (w_waiting && !bus.data_m_ack) ? r_tmo + 8'h01 : 8'h00;
            if (w_accept) begin
                r_chan        <= chan_sel;
                r_mode        <= mode;
                r_reload      <= reload;
                r_rb          <= readback_en;
                r_error       <= 1'b0;
                r_count_valid <= 1'b0;
            end
            if (w_timeout) r_error <= 1'b1;
            if (w_ack_take && r_state == READ_LO) r_count[7:0]  <= bus.data_m_data_in[7:0];
            if (w_ack_take && r_state == READ_HI) r_count[15:8] <= bus.data_m_data_in[7:0];
            if (r_state == FINISH && r_rb && !r_error) r_count_valid <= 1'b1;
        end
    end

    assign bus.cs              = w_access;
    assign bus.data_m_access   = w_access;
    assign bus.data_m_addr     = w_access ? w_addr    : 1'b0;
    assign bus.data_m_bytesel  = w_access ? w_bytesel : 2'b00;
    assign bus.data_m_wr_en    = w_access ? w_wr      : 1'b0;
    assign bus.data_m_data_out = w_access ? w_data    : 16'h0000;

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == FINISH);
    assign error       = r_error;
    assign count       = r_count;
    assign count_valid = r_count_valid;

endmodule
`default_nettype wire
